// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the integer register file and its busy scoreboard.
// Imported by every file of the register-file slice.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int ZERO_ADDR = 0;

   // Address width for n registers; never narrower than one bit.
   function automatic int addr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: issue sets a bit, writeback clears it.
// Also produces the issue-accept handshake and a registered count of busy registers.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int  NREGS    = NREGS_DEF,
   parameter bit  ZERO_REG = 1'b1,
   localparam int AW       = addr_width(NREGS),
   localparam int CW       = $clog2(NREGS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid,
   input  logic [AW-1:0]    wr_addr,
   input  logic             issue_en,
   input  logic [AW-1:0]    issue_addr,
   output logic             issue_accept,
   output logic [NREGS-1:0] busy,
   output logic [CW-1:0]    busy_count
);

   logic             issue_in_range;
   logic             issue_busy;
   logic             issue_set;
   logic             inc;
   logic             dec;
   logic [NREGS-1:0] busy_next;
   logic [CW-1:0]    count_next;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      issue_in_range = (int'(issue_addr) < NREGS);
      issue_busy     = 1'b0;
      if (issue_in_range)
         issue_busy = busy[issue_addr];

      // A same-cycle writeback to the pending register frees it for the new producer.
      issue_accept = issue_en & ~reset & issue_in_range &
                     (~issue_busy | (wr_valid & (wr_addr == issue_addr)));
      issue_set    = issue_accept & ~(ZERO_REG && (issue_addr == ZERO_ADDR[AW-1:0]));

      busy_next = busy;
      if (wr_valid)
         busy_next[wr_addr] = 1'b0;
      if (issue_set)
         busy_next[issue_addr] = 1'b1;

      inc = issue_set & ~issue_busy;
      dec = wr_valid & busy[wr_addr] & ~(issue_set & (issue_addr == wr_addr));

      count_next = busy_count;
      if (inc && !dec)
         count_next = busy_count + CW'(1);
      else if (dec && !inc)
         count_next = busy_count - CW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= busy_next;
         busy_count <= count_next;
      end
   end

endmodule

// File: rtl/register_file_scoreboard.sv
// RV32 integer register file: NUM_RD combinational read ports, one write port,
// optional hardwired x0 and write-to-read bypass, plus the busy scoreboard.
module register_file_scoreboard
   import regfile_pkg::*;
#(
   parameter int  XLEN     = XLEN_DEF,
   parameter int  NREGS    = NREGS_DEF,
   parameter int  NUM_RD   = 2,
   parameter bit  BYPASS   = 1'b1,
   parameter bit  ZERO_REG = 1'b1,
   localparam int AW       = addr_width(NREGS),
   localparam int CW       = $clog2(NREGS + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_RD*AW-1:0]   rdAddr,
   output logic [NUM_RD*XLEN-1:0] rdData,
   output logic [NUM_RD-1:0]      rdBusy,
   input  logic                   wrEn,
   input  logic [AW-1:0]          wrAddr,
   input  logic [XLEN-1:0]        wrData,
   input  logic                   issueEn,
   input  logic [AW-1:0]          issueAddr,
   output logic                   issueAccept,
   output logic [CW-1:0]          busyCount
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic             wr_valid;

   assign wr_valid = wrEn & ~reset & (int'(wrAddr) < NREGS) &
                     ~(ZERO_REG && (wrAddr == ZERO_ADDR[AW-1:0]));

   // NOTE: the array is reset on purpose: architectural state must read 0 after reset, so it maps to flops, not RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++)
            regs[r] <= '0;
      end else if (wr_valid) begin
         regs[wrAddr] <= wrData;
      end
   end

   reg_scoreboard #(
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_addr      (wrAddr),
      .issue_en     (issueEn),
      .issue_addr   (issueAddr),
      .issue_accept (issueAccept),
      .busy         (busy),
      .busy_count   (busyCount)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            bsy;

      assign addr = rdAddr[i*AW +: AW];

      always_comb begin
         data = '0;
         bsy  = 1'b0;
         if ((int'(addr) < NREGS) && !(ZERO_REG && (addr == ZERO_ADDR[AW-1:0]))) begin
            // A same-cycle issue to this register only shows as busy next cycle.
            if (BYPASS && wr_valid && (addr == wrAddr)) begin
               data = wrData;
            end else begin
               data = regs[addr];
               bsy  = busy[addr];
            end
         end
      end

      assign rdData[i*XLEN +: XLEN] = data;
      assign rdBusy[i]              = bsy;
   end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed, table-driven bench for register_file_scoreboard; a second instance
// with BYPASS=0 shares all stimulus so bypass and non-bypass reads are compared side by side.
module tb_register_file_scoreboard;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int CW   = 6;

   logic            clk = 1'b0;
   logic            reset;
   logic [2*AW-1:0] rdAddr;
   logic [2*XLEN-1:0] rdData, rdData_nb;
   logic [1:0]      rdBusy, rdBusy_nb;
   logic            wrEn;
   logic [AW-1:0]   wrAddr;
   logic [XLEN-1:0] wrData;
   logic            issueEn;
   logic [AW-1:0]   issueAddr;
   logic            issueAccept, issueAccept_nb;
   logic [CW-1:0]   busyCount, busyCount_nb;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   register_file_scoreboard dut (
      .clk (clk), .reset (reset), .rdAddr (rdAddr), .rdData (rdData), .rdBusy (rdBusy),
      .wrEn (wrEn), .wrAddr (wrAddr), .wrData (wrData), .issueEn (issueEn),
      .issueAddr (issueAddr), .issueAccept (issueAccept), .busyCount (busyCount)
   );

   register_file_scoreboard #(.BYPASS (1'b0)) dut_nb (
      .clk (clk), .reset (reset), .rdAddr (rdAddr), .rdData (rdData_nb), .rdBusy (rdBusy_nb),
      .wrEn (wrEn), .wrAddr (wrAddr), .wrData (wrData), .issueEn (issueEn),
      .issueAddr (issueAddr), .issueAccept (issueAccept_nb), .busyCount (busyCount_nb)
   );

   typedef struct {
      logic            rst;
      logic [AW-1:0]   ra0, ra1;
      logic            we;
      logic [AW-1:0]   wa;
      logic [XLEN-1:0] wd;
      logic            ie;
      logic [AW-1:0]   ia;
      logic [XLEN-1:0] e_d0, e_d1, e_nb0;
      logic            e_b0, e_b1, e_acc;
      logic [CW-1:0]   e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input int ra0, input int ra1,
                               input logic we, input int wa, input logic [31:0] wd,
                               input logic ie, input int ia,
                               input logic [31:0] e_d0, input logic [31:0] e_d1,
                               input logic [31:0] e_nb0, input logic e_b0, input logic e_b1,
                               input logic e_acc, input int e_cnt);
      vec_t v;
      v.rst = rst; v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
      v.we = we; v.wa = AW'(wa); v.wd = wd; v.ie = ie; v.ia = AW'(ia);
      v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_nb0 = e_nb0;
      v.e_b0 = e_b0; v.e_b1 = e_b1; v.e_acc = e_acc; v.e_cnt = CW'(e_cnt);
      return v;
   endfunction

   task automatic idle();
      reset = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0;
      issueEn = 1'b0; issueAddr = '0; rdAddr = '0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Post-reset sweep of every register on both ports.
      for (int a = 0; a < 32; a += 2) begin
         @(negedge clk);
         idle();
         rdAddr = {AW'(a + 1), AW'(a)};
         #1;
         check($sformatf("sweep d0 x%0d", a),     rdData[31:0],  32'h0);
         check($sformatf("sweep d1 x%0d", a + 1), rdData[63:32], 32'h0);
         check($sformatf("sweep busy @%0d", a),   32'(rdBusy),   32'h0);
         check($sformatf("sweep cnt @%0d", a),    32'(busyCount), 32'h0);
      end

      //            rst ra0 ra1 we wa wd            ie ia  e_d0          e_d1          e_nb0         b0 b1 acc cnt
      vecs.push_back(mk(0, 0, 5,  0, 0, 0,            0, 0,  0,            0,            0,            0, 0, 0, 0));
      vecs.push_back(mk(0, 5, 6,  1, 5, 32'hDEADBEEF, 0, 0,  32'hDEADBEEF, 0,            0,            0, 0, 0, 0));
      vecs.push_back(mk(0, 5, 5,  0, 0, 0,            0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 5,  1, 0, 32'h1234,     1, 0,  0,            32'hDEADBEEF, 0,            0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,  0, 0, 0,            0, 0,  0,            0,            0,            0, 0, 0, 0));
      vecs.push_back(mk(0, 7, 0,  0, 0, 0,            1, 7,  0,            0,            0,            0, 0, 1, 0));
      vecs.push_back(mk(0, 7, 0,  0, 0, 0,            1, 7,  0,            0,            0,            1, 0, 0, 1));
      vecs.push_back(mk(0, 7, 7,  1, 7, 32'h77,       0, 0,  32'h77,       32'h77,       0,            0, 0, 0, 1));
      vecs.push_back(mk(0, 7, 0,  0, 0, 0,            0, 0,  32'h77,       0,            32'h77,       0, 0, 0, 0));
      vecs.push_back(mk(0, 9, 0,  0, 0, 0,            1, 9,  0,            0,            0,            0, 0, 1, 0));
      vecs.push_back(mk(0, 9, 0,  1, 9, 32'hA5,       1, 9,  32'hA5,       0,            0,            0, 0, 1, 1));
      vecs.push_back(mk(0, 9, 0,  0, 0, 0,            0, 0,  32'hA5,       0,            32'hA5,       1, 0, 0, 1));
      vecs.push_back(mk(0, 3, 9,  1, 9, 32'hB6,       0, 0,  0,            32'hB6,       0,            0, 0, 0, 1));
      vecs.push_back(mk(0, 9, 0,  0, 0, 0,            1, 1,  32'hB6,       0,            32'hB6,       0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0,  0, 0, 0,            1, 2,  0,            0,            0,            1, 0, 1, 1));
      vecs.push_back(mk(0, 2, 0,  0, 0, 0,            1, 3,  0,            0,            0,            1, 0, 1, 2));
      vecs.push_back(mk(0, 3, 4,  0, 0, 0,            1, 4,  0,            0,            0,            1, 0, 1, 3));
      vecs.push_back(mk(1, 3, 4,  1, 3, 32'hFF,       1, 5,  0,            0,            0,            1, 1, 0, 4));
      vecs.push_back(mk(0, 3, 4,  0, 0, 0,            0, 0,  0,            0,            0,            0, 0, 0, 0));
      vecs.push_back(mk(0, 5, 9,  0, 0, 0,            0, 0,  0,            0,            0,            0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 10, 1, 10, 32'h10,      0, 0,  0,            32'h10,       0,            0, 0, 0, 0));
      vecs.push_back(mk(0, 10, 1, 0, 0, 0,            0, 0,  32'h10,       0,            32'h10,       0, 0, 0, 0));

      foreach (vecs[k]) begin
         @(negedge clk);
         reset     = vecs[k].rst;
         rdAddr    = {vecs[k].ra1, vecs[k].ra0};
         wrEn      = vecs[k].we;
         wrAddr    = vecs[k].wa;
         wrData    = vecs[k].wd;
         issueEn   = vecs[k].ie;
         issueAddr = vecs[k].ia;
         #1;
         check($sformatf("v%0d rdData0", k),    rdData[31:0],       vecs[k].e_d0);
         check($sformatf("v%0d rdData1", k),    rdData[63:32],      vecs[k].e_d1);
         check($sformatf("v%0d nb rdData0", k), rdData_nb[31:0],    vecs[k].e_nb0);
         check($sformatf("v%0d rdBusy0", k),    32'(rdBusy[0]),     32'(vecs[k].e_b0));
         check($sformatf("v%0d rdBusy1", k),    32'(rdBusy[1]),     32'(vecs[k].e_b1));
         check($sformatf("v%0d issueAccept", k), 32'(issueAccept),  32'(vecs[k].e_acc));
         check($sformatf("v%0d busyCount", k),  32'(busyCount),     32'(vecs[k].e_cnt));
         check($sformatf("v%0d nb busyCount", k), 32'(busyCount_nb), 32'(vecs[k].e_cnt));
      end

      // Fill every register except x0 with pending producers, then drain with writes.
      for (int r = 1; r < 32; r++) begin
         @(negedge clk);
         idle();
         issueEn = 1'b1; issueAddr = AW'(r);
         #1;
         check($sformatf("fill accept x%0d", r), 32'(issueAccept), 32'h1);
      end
      @(negedge clk);
      idle();
      rdAddr = {AW'(31), AW'(0)};
      #1;
      check("fill count",  32'(busyCount), 32'd31);
      check("fill busy x0", 32'(rdBusy[0]), 32'h0);
      check("fill busy x31", 32'(rdBusy[1]), 32'h1);
      for (int r = 31; r >= 1; r--) begin
         @(negedge clk);
         idle();
         wrEn = 1'b1; wrAddr = AW'(r); wrData = 32'(r * 3);
      end
      @(negedge clk);
      idle();
      rdAddr = {AW'(31), AW'(17)};
      #1;
      check("drain count",   32'(busyCount), 32'd0);
      check("drain data x17", rdData[31:0],  32'd51);
      check("drain data x31", rdData[63:32], 32'd93);
      check("drain busy",    32'(rdBusy),    32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
